// File: rtl/blake2_pkg.sv
// Shared constants and FSM encoding for the blake2 block feeder.
package blake2_pkg;

  localparam int unsigned W_DEFAULT   = 64;
  localparam int unsigned BLK_WORDS   = 16;
  localparam int unsigned BPW_DEFAULT = W_DEFAULT / 8;

  typedef enum logic {
    FILL = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/blake2_byte_mask.sv
// Zeroes every byte of a word at or above the given byte count (little-endian).
module blake2_byte_mask
  import blake2_pkg::*;
#(
  parameter  int unsigned W    = W_DEFAULT,
  localparam int unsigned BPW  = W / 8,
  localparam int unsigned BC_W = $clog2(BPW) + 1
) (
  input  logic [W-1:0]    data,
  input  logic [BC_W-1:0] bytes,
  output logic [W-1:0]    masked
);

  always_comb begin
    masked = '0;
    for (int unsigned k = 0; k < BPW; k++) begin
      if (BC_W'(k) < bytes) masked[8*k +: 8] = data[8*k +: 8];
    end
  end

endmodule

// File: rtl/blake2_block_feeder.sv
// Packs a W-bit word stream into zero-padded 16-word blake2 blocks and tracks
// the running byte offset t and final flag f for the compression core.
module blake2_block_feeder
  import blake2_pkg::*;
#(
  parameter  int unsigned W    = W_DEFAULT,
  localparam int unsigned BPW  = W / 8,
  localparam int unsigned BC_W = $clog2(BPW) + 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [W-1:0]           in_data_i,
  input  logic                   in_last_i,
  input  logic [BC_W-1:0]        in_bytes_i,
  output logic                   blk_valid_o,
  input  logic                   blk_ready_i,
  output logic [BLK_WORDS*W-1:0] blk_data_o,
  output logic [2*W-1:0]         blk_t_o,
  output logic                   blk_final_o,
  output logic                   err_o
);

  localparam int unsigned T_W   = 2 * W;
  localparam int unsigned IDX_W = $clog2(BLK_WORDS);

  state_t                       state_q, state_d;
  logic [IDX_W-1:0]             idx_q;
  logic [T_W-1:0]               t_q;
  logic [BLK_WORDS-1:0][W-1:0]  blk_q;
  logic                         final_q;
  logic                         err_q;

  logic                         accept;
  logic                         xfer;
  logic                         block_done;
  logic                         bytes_over;
  logic                         empty_bad;
  logic [BC_W-1:0]              bytes_eff;
  logic [W-1:0]                 word_masked;

  assign accept     = in_valid_i & (state_q == FILL);
  assign xfer       = blk_ready_i & (state_q == SEND);
  assign block_done = accept & (in_last_i | (idx_q == IDX_W'(BLK_WORDS - 1)));
  assign bytes_over = in_last_i & (in_bytes_i > BC_W'(BPW));
  // A zero-byte last word only makes sense as the whole (empty) message.
  assign empty_bad  = in_last_i & (in_bytes_i == '0) & (idx_q == '0) & (t_q != '0);

  always_comb begin
    bytes_eff = BC_W'(BPW);
    if (in_last_i && !bytes_over) bytes_eff = in_bytes_i;
  end

  blake2_byte_mask #(.W(W)) u_mask (
    .data   (in_data_i),
    .bytes  (bytes_eff),
    .masked (word_masked)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= FILL;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      FILL:    if (block_done) state_d = SEND;
      SEND:    if (xfer)       state_d = FILL;
      default: state_d = FILL;
    endcase
  end

  // FSM outputs
  always_comb begin
    in_ready_o  = 1'b0;
    blk_valid_o = 1'b0;
    case (state_q)
      FILL:    in_ready_o  = 1'b1;
      SEND:    blk_valid_o = 1'b1;
      default: in_ready_o  = 1'b0;
    endcase
  end

  // Block buffer, word index, byte offset and flags
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= '0;
      t_q     <= '0;
      blk_q   <= '0;
      final_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      err_q <= accept & (bytes_over | empty_bad);
      if (accept) begin
        blk_q[idx_q] <= word_masked;
        t_q          <= t_q + T_W'(bytes_eff);
        idx_q        <= IDX_W'(idx_q + IDX_W'(1));
        if (block_done) final_q <= in_last_i;
      end
      if (xfer) begin
        idx_q   <= '0;
        blk_q   <= '0;
        final_q <= 1'b0;
        if (final_q) t_q <= '0;
      end
    end
  end

  assign blk_data_o  = blk_q;
  assign blk_t_o     = t_q;
  assign blk_final_o = final_q;
  assign err_o       = err_q;

endmodule

// File: tb/tb_blake2_block_feeder.sv
// Directed bench for blake2_block_feeder with W=64.
module tb_blake2_block_feeder;

  localparam int unsigned W    = 64;
  localparam int unsigned BC_W = 4;

  logic              clk = 1'b0;
  logic              reset;
  logic              in_valid_i;
  logic              in_ready_o;
  logic [W-1:0]      in_data_i;
  logic              in_last_i;
  logic [BC_W-1:0]   in_bytes_i;
  logic              blk_valid_o;
  logic              blk_ready_i;
  logic [16*W-1:0]   blk_data_o;
  logic [2*W-1:0]    blk_t_o;
  logic              blk_final_o;
  logic              err_o;

  int checks = 0;
  int errors = 0;

  logic [15:0][63:0] exp_blk;
  logic [15:0][63:0] got_blk;
  logic [63:0]       held_w0;
  logic [127:0]      held_t;

  blake2_block_feeder #(.W(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .in_last_i   (in_last_i),
    .in_bytes_i  (in_bytes_i),
    .blk_valid_o (blk_valid_o),
    .blk_ready_i (blk_ready_i),
    .blk_data_o  (blk_data_o),
    .blk_t_o     (blk_t_o),
    .blk_final_o (blk_final_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  assign got_blk = blk_data_o;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    in_valid_i = 1'b0;
    blk_ready_i = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic send_word(input logic [63:0] data, input logic last, input logic [3:0] nbytes);
    int n;
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = data;
    in_last_i  = last;
    in_bytes_i = nbytes;
    n = 0;
    while (!in_ready_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n == 50) check("in_ready_timeout", 0, 1);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic expect_block(input string tag, input logic [127:0] exp_t, input logic exp_final);
    int n;
    n = 0;
    while (!blk_valid_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_valid"}, 128'(blk_valid_o), 1);
    check({tag, "_in_ready"}, 128'(in_ready_o), 0);
    for (int j = 0; j < 16; j++)
      check($sformatf("%s_w%0d", tag, j), 128'(got_blk[j]), 128'(exp_blk[j]));
    check({tag, "_t"}, blk_t_o, exp_t);
    check({tag, "_final"}, 128'(blk_final_o), 128'(exp_final));
    @(negedge clk);
    blk_ready_i = 1'b1;
    @(posedge clk);
    #1 blk_ready_i = 1'b0;
    check({tag, "_done"}, 128'(blk_valid_o), 0);
  endtask

  initial begin
    reset = 1'b0;
    in_valid_i = 1'b0;
    in_data_i = '0;
    in_last_i = 1'b0;
    in_bytes_i = '0;
    blk_ready_i = 1'b0;
    do_reset();

    check("rst_in_ready", 128'(in_ready_o), 1);
    check("rst_valid", 128'(blk_valid_o), 0);
    check("rst_err", 128'(err_o), 0);
    check("rst_t", blk_t_o, 0);
    check("rst_final", 128'(blk_final_o), 0);
    check("rst_data", 128'(blk_data_o[127:0]), 0);

    // "abc": valid the cycle after the accept edge
    send_word(64'h0000000000636261, 1'b1, 4'd3);
    check("abc_latency", 128'(blk_valid_o), 1);
    check("abc_err", 128'(err_o), 0);
    exp_blk = '0;
    exp_blk[0] = 64'h636261;
    expect_block("abc", 128'd3, 1'b1);
    check("abc_in_ready_after", 128'(in_ready_o), 1);

    // empty message; nonzero data must be masked away
    send_word(64'hDEADBEEFDEADBEEF, 1'b1, 4'd0);
    check("empty_err", 128'(err_o), 0);
    exp_blk = '0;
    expect_block("empty", 128'd0, 1'b1);

    // exactly 128 bytes: one final block, no padding block
    for (int i = 0; i < 16; i++)
      send_word(64'h0101010101010101, i == 15, 4'd8);
    exp_blk = '0;
    for (int j = 0; j < 16; j++) exp_blk[j] = 64'h0101010101010101;
    expect_block("b128", 128'd128, 1'b1);
    repeat (5) @(negedge clk);
    check("b128_no_extra", 128'(blk_valid_o), 0);

    // 136 bytes: full non-final block then a padded final one
    for (int i = 0; i < 16; i++)
      send_word(64'h0202020202020202, 1'b0, 4'd8);
    exp_blk = '0;
    for (int j = 0; j < 16; j++) exp_blk[j] = 64'h0202020202020202;
    expect_block("b136a", 128'd128, 1'b0);
    send_word(64'h0303030303030303, 1'b1, 4'd8);
    exp_blk = '0;
    exp_blk[0] = 64'h0303030303030303;
    expect_block("b136b", 128'd136, 1'b1);

    // backpressure: a pending word must not be taken while in SEND
    send_word(64'h1122334455667788, 1'b1, 4'd5);
    held_w0 = got_blk[0];
    held_t  = blk_t_o;
    check("bp_w0", 128'(held_w0), 128'h0000004455667788);
    check("bp_t", held_t, 128'd5);
    @(negedge clk);
    in_valid_i = 1'b1;
    in_data_i  = 64'h00000000000000AB;
    in_last_i  = 1'b1;
    in_bytes_i = 4'd1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_valid_%0d", c), 128'(blk_valid_o), 1);
      check($sformatf("bp_ready_%0d", c), 128'(in_ready_o), 0);
      check($sformatf("bp_w0_%0d", c), 128'(got_blk[0]), 128'h0000004455667788);
      check($sformatf("bp_t_%0d", c), blk_t_o, 128'd5);
    end
    blk_ready_i = 1'b1;
    @(posedge clk);
    #1 blk_ready_i = 1'b0;
    check("bp_xfer", 128'(blk_valid_o), 0);
    @(posedge clk);
    #1 in_valid_i = 1'b0;
    exp_blk = '0;
    exp_blk[0] = 64'hAB;
    expect_block("bp_next", 128'd1, 1'b1);

    // byte masking
    send_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd2);
    exp_blk = '0;
    exp_blk[0] = 64'hFFFF;
    expect_block("mask", 128'd2, 1'b1);

    // oversize byte count: clamped to 8, error pulse
    send_word(64'hFFFFFFFFFFFFFFFF, 1'b1, 4'd12);
    check("clamp_err", 128'(err_o), 1);
    @(posedge clk);
    #1 check("clamp_err_pulse", 128'(err_o), 0);
    exp_blk = '0;
    exp_blk[0] = 64'hFFFFFFFFFFFFFFFF;
    expect_block("clamp", 128'd8, 1'b1);

    // zero-byte last word at a block boundary with t != 0
    for (int i = 0; i < 16; i++)
      send_word(64'h0404040404040404, 1'b0, 4'd8);
    exp_blk = '0;
    for (int j = 0; j < 16; j++) exp_blk[j] = 64'h0404040404040404;
    expect_block("viol_a", 128'd128, 1'b0);
    send_word(64'h5555555555555555, 1'b1, 4'd0);
    check("viol_err", 128'(err_o), 1);
    exp_blk = '0;
    expect_block("viol_b", 128'd128, 1'b1);

    // reset mid-block discards partial data
    for (int i = 0; i < 7; i++)
      send_word(64'h0606060606060606, 1'b0, 4'd8);
    do_reset();
    check("mrst_valid", 128'(blk_valid_o), 0);
    check("mrst_ready", 128'(in_ready_o), 1);
    check("mrst_t", blk_t_o, 0);
    send_word(64'h0000000000636261, 1'b1, 4'd3);
    exp_blk = '0;
    exp_blk[0] = 64'h636261;
    expect_block("mrst_abc", 128'd3, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
